pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_pkg.sv | 19 +
 rtl/pwm_fade_regs.sv | 97 +++++++++
 rtl/pwm_fade_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
// rtl/pwm_fade_pkg.sv - shared FSM state type and register map for the PWM fade sequencer
package pwm_fade_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_SCAN = 2'd2,
    ST_REQ  = 2'd3
  } fade_state_e;

  localparam logic [9:0] CH_CFG_BASE   = 10'h000;
  localparam logic [9:0] CTRL_OFFSET   = 10'h100;
  localparam logic [9:0] STATUS_OFFSET = 10'h104;
  localparam logic [9:0] LEVEL_BASE    = 10'h200;

  localparam int PERIOD_W = 16;
  localparam int STEP_W   = 8;

endpackage

// File: rtl/pwm_fade_regs.sv
// rtl/pwm_fade_regs.sv - config register file and registered read mux for the fade sequencer
module pwm_fade_regs
  import pwm_fade_pkg::*;
#(
  parameter int NumCh    = 12,
  parameter int CtrSize  = 8,
  parameter int BusWidth = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [BusWidth-1:0]         addr_i,
  input  logic [BusWidth-1:0]         wdata_i,
  input  logic                        busy_i,
  input  logic                        overrun_set_i,
  input  logic [NumCh*CtrSize-1:0]    level_i,
  output logic [NumCh*CtrSize-1:0]    target_o,
  output logic [NumCh*STEP_W-1:0]     step_o,
  output logic [PERIOD_W-1:0]         period_o,
  output logic                        enable_o,
  output logic                        rvalid_o,
  output logic [BusWidth-1:0]         rdata_o
);

  localparam int ChW = (NumCh > 1) ? $clog2(NumCh) : 1;

  logic [9:0]          offs;
  logic [5:0]          word;
  logic [ChW-1:0]      ch_idx;
  logic                in_range, cfg_hit, level_hit, ctrl_hit, status_hit, wr_en;
  logic                overrun_q;
  logic [BusWidth-1:0] rd_mux;
  logic                unused_bits;

  assign offs       = addr_i[9:0];
  assign word       = offs[7:2];
  assign ch_idx     = word[ChW-1:0];
  assign in_range   = (offs[1:0] == 2'b00) && ({1'b0, word} < 7'(NumCh));
  assign cfg_hit    = in_range && (offs[9:8] == CH_CFG_BASE[9:8]);
  assign level_hit  = in_range && (offs[9:8] == LEVEL_BASE[9:8]);
  assign ctrl_hit   = (offs == CTRL_OFFSET);
  assign status_hit = (offs == STATUS_OFFSET);
  assign wr_en      = req_i && we_i;
  assign unused_bits = ^{addr_i, wdata_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_o  <= '0;
      step_o    <= '0;
      period_o  <= '0;
      enable_o  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // A new overrun in the same cycle as a W1C keeps the flag set.
      if (overrun_set_i) begin
        overrun_q <= 1'b1;
      end else if (wr_en && status_hit && wdata_i[1]) begin
        overrun_q <= 1'b0;
      end
      if (wr_en && cfg_hit) begin
        target_o[ch_idx*CtrSize +: CtrSize] <= wdata_i[CtrSize-1:0];
        step_o[ch_idx*STEP_W +: STEP_W]     <= wdata_i[CtrSize+STEP_W-1:CtrSize];
      end
      if (wr_en && ctrl_hit) begin
        enable_o <= wdata_i[31];
        period_o <= wdata_i[PERIOD_W-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (cfg_hit) begin
      rd_mux[CtrSize+STEP_W-1:0] = {step_o[ch_idx*STEP_W +: STEP_W],
                                    target_o[ch_idx*CtrSize +: CtrSize]};
    end else if (level_hit) begin
      rd_mux[CtrSize-1:0] = level_i[ch_idx*CtrSize +: CtrSize];
    end else if (ctrl_hit) begin
      rd_mux[31]           = enable_o;
      rd_mux[PERIOD_W-1:0] = period_o;
    end else if (status_hit) begin
      rd_mux[1:0] = {overrun_q, busy_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= req_i;
      rdata_o  <= (req_i && !we_i) ? rd_mux : '0;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - ticks a prescaler and walks each PWM channel's level toward its target
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int NumCh    = 12,
  parameter int CtrSize  = 8,
  parameter int BusWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                device_req_i,
  input  logic                device_we_i,
  input  logic [BusWidth-1:0] device_addr_i,
  input  logic [BusWidth-1:0] device_wdata_i,
  input  logic [3:0]          device_be_i,
  output logic                device_rvalid_o,
  output logic [BusWidth-1:0] device_rdata_o,
  output logic                host_req_o,
  output logic                host_we_o,
  output logic [BusWidth-1:0] host_addr_o,
  output logic [BusWidth-1:0] host_wdata_o,
  output logic [3:0]          host_be_o,
  input  logic                host_gnt_i,
  input  logic                host_rvalid_i
);

  localparam int ChW = (NumCh > 1) ? $clog2(NumCh) : 1;
  // Wide enough that level+step never wraps, even for steps wider than CtrSize.
  localparam int AW  = ((CtrSize > STEP_W) ? CtrSize : STEP_W) + 1;

  logic [NumCh*CtrSize-1:0] target_flat, level_flat;
  logic [NumCh*STEP_W-1:0]  step_flat;
  logic [PERIOD_W-1:0]      period, presc_q;
  logic                     enable, enable_prev, enable_rise;
  logic                     tick, pending_q, init_pend_q, overrun_set, busy;
  fade_state_e              state_q, state_d;
  logic [ChW-1:0]           ch_q, ch_d;
  logic [CtrSize-1:0]       level_q [NumCh];
  logic [CtrSize-1:0]       cur_level, cur_target, next_val, next_q;
  logic [STEP_W-1:0]        cur_step;
  logic [AW-1:0]            lvl_w, tgt_w, stp_w;
  logic                     last_ch, start_scan, start_init, load_next, level_we;
  logic                     unused_inputs;

  assign unused_inputs = ^{host_rvalid_i, device_be_i};
  assign busy          = (state_q != ST_IDLE);
  assign enable_rise   = enable && !enable_prev;
  assign tick          = enable && (presc_q >= period);
  assign overrun_set   = tick && pending_q;

  pwm_fade_regs #(.NumCh(NumCh), .CtrSize(CtrSize), .BusWidth(BusWidth)) u_regs (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (device_req_i),
    .we_i          (device_we_i),
    .addr_i        (device_addr_i),
    .wdata_i       (device_wdata_i),
    .busy_i        (busy),
    .overrun_set_i (overrun_set),
    .level_i       (level_flat),
    .target_o      (target_flat),
    .step_o        (step_flat),
    .period_o      (period),
    .enable_o      (enable),
    .rvalid_o      (device_rvalid_o),
    .rdata_o       (device_rdata_o)
  );

  always_comb begin
    level_flat = '0;
    for (int i = 0; i < NumCh; i++) level_flat[i*CtrSize +: CtrSize] = level_q[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q     <= '0;
      pending_q   <= 1'b0;
      init_pend_q <= 1'b0;
      enable_prev <= 1'b0;
    end else begin
      enable_prev <= enable;
      presc_q     <= (!enable || tick) ? '0 : presc_q + 1'b1;
      if (!enable)                    pending_q <= 1'b0;
      else if (tick && !pending_q)    pending_q <= 1'b1;
      else if (start_scan)            pending_q <= 1'b0;
      // Remembers a re-enable that arrives while a disabled transfer is still draining.
      if (!enable || start_init)      init_pend_q <= 1'b0;
      else if (enable_rise)           init_pend_q <= 1'b1;
    end
  end

  assign cur_level  = level_q[ch_q];
  assign cur_target = target_flat[ch_q*CtrSize +: CtrSize];
  assign cur_step   = step_flat[ch_q*STEP_W +: STEP_W];
  assign lvl_w      = AW'(cur_level);
  assign tgt_w      = AW'(cur_target);
  assign stp_w      = AW'(cur_step);
  assign last_ch    = (ch_q == ChW'(NumCh - 1));

  always_comb begin
    next_val = cur_level;
    if (lvl_w < tgt_w) begin
      next_val = (stp_w >= tgt_w - lvl_w) ? cur_target : CtrSize'(lvl_w + stp_w);
    end else if (lvl_w > tgt_w) begin
      next_val = (stp_w >= lvl_w - tgt_w) ? cur_target : CtrSize'(lvl_w - stp_w);
    end
  end

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    start_scan   = 1'b0;
    start_init   = 1'b0;
    load_next    = 1'b0;
    level_we     = 1'b0;
    host_req_o   = 1'b0;
    host_we_o    = 1'b0;
    host_be_o    = 4'h0;
    host_addr_o  = '0;
    host_wdata_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable && (enable_rise || init_pend_q)) begin
          start_init = 1'b1;
          ch_d       = '0;
          state_d    = ST_INIT;
        end else if (enable && pending_q) begin
          start_scan = 1'b1;
          ch_d       = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_INIT: begin
        host_req_o   = 1'b1;
        host_we_o    = 1'b1;
        host_be_o    = 4'hF;
        host_addr_o  = BusWidth'({ch_q, 3'b100});
        host_wdata_o = BusWidth'({CtrSize{1'b1}});
        if (host_gnt_i) begin
          if (last_ch || !enable) state_d = ST_IDLE;
          else                    ch_d    = ch_q + 1'b1;
        end
      end
      ST_SCAN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (next_val != cur_level) begin
          load_next = 1'b1;
          state_d   = ST_REQ;
        end else if (last_ch) begin
          state_d = ST_IDLE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      ST_REQ: begin
        host_req_o   = 1'b1;
        host_we_o    = 1'b1;
        host_be_o    = 4'hF;
        host_addr_o  = BusWidth'({ch_q, 3'b000});
        host_wdata_o = BusWidth'(next_q);
        if (host_gnt_i) begin
          level_we = 1'b1;
          if (last_ch || !enable) begin
            state_d = ST_IDLE;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      next_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      if (load_next) next_q <= next_val;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCh; i++) level_q[i] <= '0;
    end else if (level_we) begin
      level_q[ch_q] <= next_q;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - directed self-checking bench for pwm_fade_ctrl
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dev_req = 1'b0, dev_we = 1'b0;
  logic [31:0] dev_addr = '0, dev_wdata = '0;
  logic [3:0]  dev_be = 4'hF;
  logic        dev_rvalid;
  logic [31:0] dev_rdata;
  logic        host_req, host_we, host_gnt, host_rvalid = 1'b0;
  logic [31:0] host_addr, host_wdata;
  logic [3:0]  host_be;
  logic        gnt_auto = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int req_cycles = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_t[$];
  logic [31:0] rd;

  assign host_gnt = gnt_auto & host_req;

  always #5 clk = ~clk;

  pwm_fade_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .device_req_i(dev_req), .device_we_i(dev_we), .device_addr_i(dev_addr),
    .device_wdata_i(dev_wdata), .device_be_i(dev_be),
    .device_rvalid_o(dev_rvalid), .device_rdata_o(dev_rdata),
    .host_req_o(host_req), .host_we_o(host_we), .host_addr_o(host_addr),
    .host_wdata_o(host_wdata), .host_be_o(host_be),
    .host_gnt_i(host_gnt), .host_rvalid_i(host_rvalid)
  );

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (host_req) req_cycles = req_cycles + 1;
    if (host_req && host_gnt) begin
      wq_addr.push_back(host_addr);
      wq_data.push_back(host_wdata);
      wq_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    dev_req = 1'b1; dev_we = 1'b1; dev_addr = a; dev_wdata = d;
    @(negedge clk);
    dev_req = 1'b0; dev_we = 1'b0;
    check("wr_rvalid", {31'b0, dev_rvalid}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    dev_req = 1'b1; dev_we = 1'b0; dev_addr = a;
    @(negedge clk);
    dev_req = 1'b0;
    check("rd_rvalid", {31'b0, dev_rvalid}, 32'd1);
    d = dev_rdata;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 100 && !host_req; i++) @(negedge clk);
    check(tag, {31'b0, host_req}, 32'd1);
  endtask

  task automatic clear_q();
    wq_addr.delete(); wq_data.delete(); wq_t.delete();
  endtask

  initial begin
    // reset state
    wait_cycles(2);
    check("rst_host_req", {31'b0, host_req}, 32'd0);
    check("rst_host_we", {31'b0, host_we}, 32'd0);
    check("rst_host_addr", host_addr, 32'd0);
    check("rst_host_wdata", host_wdata, 32'd0);
    check("rst_host_be", {28'b0, host_be}, 32'd0);
    check("rst_dev_rvalid", {31'b0, dev_rvalid}, 32'd0);
    check("rst_dev_rdata", dev_rdata, 32'd0);
    rst_n = 1'b1;
    wait_cycles(2);
    bus_read(32'h104, rd); check("rst_status", rd, 32'h0);
    bus_read(32'h100, rd); check("rst_ctrl", rd, 32'h0);

    // INIT sweep followed by the ch0 fade 0 -> 0x10 in steps of 6
    gnt_auto = 1'b1;
    bus_write(32'h000, 32'h0000_0610);
    bus_read(32'h000, rd); check("cfg0_rb", rd, 32'h0000_0610);
    bus_read(32'h030, rd); check("cfg_oob_rd", rd, 32'h0);
    bus_read(32'h300, rd); check("unmapped_rd", rd, 32'h0);
    clear_q();
    bus_write(32'h100, 32'h8000_0003);
    wait_cycles(200);
    check("init_fade_cnt", wq_addr.size(), 32'd15);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("init_addr%0d", k), wq_addr[k], 32'(8 * k + 4));
      check($sformatf("init_data%0d", k), wq_data[k], 32'hFF);
    end
    check("fade_addr0", wq_addr[12], 32'h0); check("fade_data0", wq_data[12], 32'h06);
    check("fade_addr1", wq_addr[13], 32'h0); check("fade_data1", wq_data[13], 32'h0C);
    check("fade_addr2", wq_addr[14], 32'h0); check("fade_data2", wq_data[14], 32'h10);
    check("fade_gap1", {31'b0, (wq_t[13] - wq_t[12]) >= 4}, 32'd1);
    check("fade_gap2", {31'b0, (wq_t[14] - wq_t[13]) >= 4}, 32'd1);
    bus_read(32'h200, rd); check("level0_done", rd, 32'h10);
    bus_read(32'h100, rd); check("ctrl_rb", rd, 32'h8000_0003);

    // grant stall on ch1 (target 5, step 5), then period 0 to force overruns
    gnt_auto = 1'b0;
    clear_q();
    bus_write(32'h004, 32'h0000_0505);
    wait_req("stall_req_seen");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", k),
            {7'b0, host_req, host_addr[15:0], host_wdata[7:0]},
            {7'b0, 1'b1, 16'h0008, 8'h05});
    end
    check("stall_be", {27'b0, host_we, host_be}, {27'b0, 1'b1, 4'hF});
    bus_read(32'h204, rd); check("level1_stalled", rd, 32'h0);
    bus_write(32'h100, 32'h8000_0000);
    wait_cycles(4);
    bus_read(32'h104, rd); check("status_overrun", rd, 32'h3);

    // disable mid-transfer: write still completes on grant, then nothing more
    bus_write(32'h100, 32'h0000_0000);
    wait_cycles(3);
    check("dis_req_held", {host_req, 15'b0, host_addr[15:0]}, {1'b1, 15'b0, 16'h0008});
    bus_read(32'h104, rd); check("dis_status_busy", rd, 32'h3);
    gnt_auto = 1'b1;
    @(negedge clk);
    gnt_auto = 1'b0;
    check("dis_wr_cnt", wq_addr.size(), 32'd1);
    check("dis_wr_addr", wq_addr[0], 32'h8);
    check("dis_wr_data", wq_data[0], 32'h5);
    req_cycles = 0;
    wait_cycles(20);
    check("dis_no_req", req_cycles, 32'd0);
    bus_read(32'h204, rd); check("level1_done", rd, 32'h5);
    bus_read(32'h104, rd); check("dis_status_idle", rd, 32'h2);
    bus_write(32'h104, 32'h2);
    bus_read(32'h104, rd); check("status_w1c", rd, 32'h0);

    // re-enable, stall ch2 in REQ, then reset mid-transfer
    gnt_auto = 1'b1;
    clear_q();
    bus_write(32'h100, 32'h8000_0003);
    wait_cycles(60);
    check("reinit_cnt", wq_addr.size(), 32'd12);
    gnt_auto = 1'b0;
    bus_write(32'h008, 32'h0000_0303);
    wait_req("rst_req_seen");
    check("rst_req_target", {host_addr[15:0], host_wdata[15:0]}, {16'h0010, 16'h0003});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req_drop", {31'b0, host_req}, 32'd0);
    check("async_addr_drop", host_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);
    bus_read(32'h200, rd); check("post_rst_level0", rd, 32'h0);
    bus_read(32'h204, rd); check("post_rst_level1", rd, 32'h0);
    bus_read(32'h100, rd); check("post_rst_ctrl", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
